// File: rtl/axi_mem_responder_pkg.sv
// axi_mem_responder_pkg: response codes, FSM states and range helper shared by the responder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi_mem_responder_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // RD_WAIT is only entered when the registered read path is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4,
    RD_WAIT = 3'd5
  } state_e;

  // The full address is compared, so aliases above the array never decode.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] mem_bytes);
    return addr < mem_bytes;
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4-Lite channel bundle; names keep the subordinate's _i/_o view.
// Latency: none (wires only).
// Backpressure: carried by the ready/valid pairs of each channel.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0]   awaddr_i;
  logic                    awvalid_i;
  logic                    awready_o;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] wstrb_i;
  logic                    wvalid_i;
  logic                    wready_o;
  logic [1:0]              bresp_o;
  logic                    bvalid_o;
  logic                    bready_i;
  logic [ADDR_WIDTH-1:0]   araddr_i;
  logic                    arvalid_i;
  logic                    arready_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic [1:0]              rresp_o;
  logic                    rvalid_o;
  logic                    rready_i;

  modport master (
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o,
           rdata_o, rresp_o, rvalid_o
  );

  modport slave (
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o,
           rdata_o, rresp_o, rvalid_o
  );

endinterface

// File: rtl/axi_mem_responder_array.sv
// axi_mem_responder_array: byte-enabled word array, one write port and one asynchronous read port.
// Latency: write lands on the clock edge with we_i high; read is combinational from ridx_i.
// Backpressure: none, accepts a write every cycle. Contents are deliberately not reset.
module axi_mem_responder_array
  import axi_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [IDX_W-1:0]        ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write: only lanes with their strobe set are touched.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (strb_i[k]) begin
          mem_q[widx_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4-Lite subordinate over an internal word array, one transaction in flight.
// Latency: write commits on the completing AW/W edge, bvalid next cycle; read 1 cycle AR->rvalid
//          (2 cycles with AXI_MEM_RESPONDER_RD_PIPE_EN defined). Backpressure: B/R held until ready; no new AR/AW/W meanwhile.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_BYTES  = 8192
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  axi_mem_responder_if.slave bus
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NB);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int IDX_W  = MEM_AW - OFF;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  bvalid_q;
  logic                  rvalid_q;
  resp_e                 bresp_q;
  resp_e                 rresp_q;

  logic                  aw_rdy, w_rdy, ar_rdy;
  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data, mem_rdata;
  logic [NB-1:0]         wr_strb;
  logic                  wr_commit, wr_ok, rd_ok, mem_we;

  // Readies follow the state; held low during reset. Pending writes block AR so writes win.
  always_comb begin
    aw_rdy = rst_ni && (state_q == IDLE || state_q == WAIT_AW);
    w_rdy  = rst_ni && (state_q == IDLE || state_q == WAIT_W);
    ar_rdy = rst_ni && (state_q == IDLE) && !bus.awvalid_i && !bus.wvalid_i;
    aw_hs  = bus.awvalid_i && aw_rdy;
    w_hs   = bus.wvalid_i && w_rdy;
    ar_hs  = bus.arvalid_i && ar_rdy;
  end

  // Pick the write operands from the live bus or the half captured earlier.
  always_comb begin
    wr_addr   = (state_q == WAIT_W)  ? addr_q  : bus.awaddr_i;
    wr_data   = (state_q == WAIT_AW) ? wdata_q : bus.wdata_i;
    wr_strb   = (state_q == WAIT_AW) ? strb_q  : bus.wstrb_i;
    wr_commit = ((state_q == IDLE) && aw_hs && w_hs) ||
                ((state_q == WAIT_W) && w_hs) ||
                ((state_q == WAIT_AW) && aw_hs);
    wr_ok     = addr_in_range(64'(wr_addr), 64'(MEM_BYTES));
    mem_we    = wr_commit && wr_ok;
`ifdef AXI_MEM_RESPONDER_RD_PIPE_EN
    rd_addr   = addr_q;
`else
    rd_addr   = bus.araddr_i;
`endif
    rd_ok     = addr_in_range(64'(rd_addr), 64'(MEM_BYTES));
  end

  axi_mem_responder_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .widx_i  (wr_addr[MEM_AW-1:OFF]),
    .wdata_i (wr_data),
    .strb_i  (wr_strb),
    .ridx_i  (rd_addr[MEM_AW-1:OFF]),
    .rdata_o (mem_rdata)
  );

  // Transaction FSM with registered response channels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rresp_q  <= OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs && w_hs) begin
            bresp_q  <= wr_ok ? OKAY : DECERR;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end else if (aw_hs) begin
            addr_q  <= bus.awaddr_i;
            state_q <= WAIT_W;
          end else if (w_hs) begin
            wdata_q <= bus.wdata_i;
            strb_q  <= bus.wstrb_i;
            state_q <= WAIT_AW;
          end else if (ar_hs) begin
`ifdef AXI_MEM_RESPONDER_RD_PIPE_EN
            addr_q  <= bus.araddr_i;
            state_q <= RD_WAIT;
`else
            rdata_q  <= rd_ok ? mem_rdata : '0;
            rresp_q  <= rd_ok ? OKAY : DECERR;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
`endif
          end
        end
        WAIT_W: begin
          if (w_hs) begin
            bresp_q  <= wr_ok ? OKAY : DECERR;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WAIT_AW: begin
          if (aw_hs) begin
            bresp_q  <= wr_ok ? OKAY : DECERR;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD_WAIT: begin
`ifdef AXI_MEM_RESPONDER_RD_PIPE_EN
          rdata_q  <= rd_ok ? mem_rdata : '0;
          rresp_q  <= rd_ok ? OKAY : DECERR;
          rvalid_q <= 1'b1;
          state_q  <= RD_RESP;
`else
          state_q  <= IDLE;
`endif
        end
        RD_RESP: begin
          if (bus.rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.awready_o = aw_rdy;
  assign bus.wready_o  = w_rdy;
  assign bus.arready_o = ar_rdy;
  assign bus.bvalid_o  = bvalid_q;
  assign bus.bresp_o   = bresp_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rresp_o   = rresp_q;
  assign bus.rdata_o   = rdata_q;

endmodule
